// File: rtl/rwt_tag_pkg.sv
// Shared types for the tag insert/extract pair: parser states and the descriptor word layout.
package rwt_tag_pkg;

    localparam int unsigned TAG_TTWIDTH_DEFAULT = 7;
    localparam int unsigned TAG_DWIDTH_DEFAULT  = 64;

    typedef enum logic [1:0] {
        S_DATA,
        S_ESC,
        S_TAG,
        S_TESC
    } tag_extract_state_t;

    typedef struct packed {
        logic [TAG_DWIDTH_DEFAULT-TAG_TTWIDTH_DEFAULT-1:0] reserved;
        logic [TAG_TTWIDTH_DEFAULT-1:0]                    tag_type;
    } tag_desc_t;

endpackage

// File: rtl/rwt_tag_extract_if.sv
// Input and output AXIS streams of the tag extractor; slave is the extractor, master the far side.
interface rwt_tag_extract_if
    import rwt_tag_pkg::*;
#(
    parameter int unsigned DWIDTH  = TAG_DWIDTH_DEFAULT,
    parameter int unsigned TTWIDTH = TAG_TTWIDTH_DEFAULT
);

    logic [DWIDTH-1:0]  s_axi_tdata;
    logic               s_axi_tvalid;
    logic               s_axi_tready;
    logic               s_axi_tlast;
    logic [DWIDTH-1:0]  m_axi_tdata;
    logic               m_axi_tvalid;
    logic               m_axi_tready;
    logic               m_axi_tlast;
    logic               m_axi_tag_valid;
    logic [TTWIDTH-1:0] m_axi_tag_type;

    modport master (
        output s_axi_tdata, s_axi_tvalid, s_axi_tlast, m_axi_tready,
        input  s_axi_tready, m_axi_tdata, m_axi_tvalid, m_axi_tlast, m_axi_tag_valid,
        input  m_axi_tag_type
    );

    modport slave (
        input  s_axi_tdata, s_axi_tvalid, s_axi_tlast, m_axi_tready,
        output s_axi_tready, m_axi_tdata, m_axi_tvalid, m_axi_tlast, m_axi_tag_valid,
        output m_axi_tag_type
    );

endinterface

// File: rtl/rwt_axis_skid.sv
// Two-entry register slice; ready depends only on the registered fill level.
module rwt_axis_skid #(
    parameter int unsigned WIDTH = 73
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_q;
    logic             wr_q;
    logic [1:0]       cnt_q;
    logic             push;
    logic             pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= in_data;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/rwt_tag_extract.sv
// Strips escape/descriptor words from a tagged AXIS stream and emits per-beat tag sideband.
// Optional RWT_TAG_EXTRACT_ERR_CNT_EN adds a saturating protocol error counter with clear.
module rwt_tag_extract
    import rwt_tag_pkg::*;
#(
    parameter int unsigned DWIDTH  = TAG_DWIDTH_DEFAULT,
    parameter int unsigned TTWIDTH = TAG_TTWIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              use_tags,
    input  logic [DWIDTH-1:0] tag_escape,
    rwt_tag_extract_if.slave  axi,
`ifdef RWT_TAG_EXTRACT_ERR_CNT_EN
    input  logic              err_clear,
    output logic [15:0]       err_count,
`endif
    output logic              proto_err
);

    tag_extract_state_t state_q, state_d;
    logic [TTWIDTH-1:0] type_q, type_d;
    logic               pkt_start_q;
    logic               tags_q;
    logic               proto_err_q;
    logic               s_ready;
    logic               accept;
    logic               tags_eff;
    logic               is_esc;
    logic               rsvd_bad;
    logic               last;
    logic               emit;
    logic               emit_tag;
    logic               err;
    logic [DWIDTH+TTWIDTH+1:0] skid_in;
    logic [DWIDTH+TTWIDTH+1:0] skid_out;

    assign axi.s_axi_tready = s_ready;
    assign accept   = axi.s_axi_tvalid && s_ready;
    assign last     = axi.s_axi_tlast;
    // use_tags is only honoured on the first beat of a packet, then held.
    assign tags_eff = pkt_start_q ? use_tags : tags_q;
    assign is_esc   = (axi.s_axi_tdata == tag_escape);
    assign rsvd_bad = |axi.s_axi_tdata[DWIDTH-1:TTWIDTH];

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        emit     = 1'b0;
        emit_tag = 1'b0;
        err      = 1'b0;
        if (accept) begin
            if (!tags_eff) begin
                emit    = 1'b1;
                state_d = S_DATA;
            end else begin
                unique case (state_q)
                    S_DATA: begin
                        if (!is_esc) emit = 1'b1;
                        else if (last) err = 1'b1;
                        else state_d = S_ESC;
                    end
                    S_ESC: begin
                        state_d = S_DATA;
                        if (is_esc) begin
                            emit = 1'b1;
                        end else if (last || rsvd_bad) begin
                            err = 1'b1;
                        end else begin
                            type_d  = axi.s_axi_tdata[TTWIDTH-1:0];
                            state_d = S_TAG;
                        end
                    end
                    S_TAG: begin
                        state_d = S_DATA;
                        if (!is_esc) begin
                            emit     = 1'b1;
                            emit_tag = 1'b1;
                        end else if (last) begin
                            err = 1'b1;
                        end else begin
                            state_d = S_TESC;
                        end
                    end
                    S_TESC: begin
                        state_d  = S_DATA;
                        emit     = is_esc;
                        emit_tag = is_esc;
                        err      = !is_esc;
                    end
                    default: state_d = S_DATA;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_DATA;
            type_q      <= '0;
            pkt_start_q <= 1'b1;
            tags_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            proto_err_q <= err;
            if (accept) begin
                pkt_start_q <= last;
                if (pkt_start_q) tags_q <= use_tags;
            end
        end
    end

    assign proto_err = proto_err_q;
    assign skid_in   = {axi.s_axi_tdata, last, emit_tag, emit_tag ? type_q : '0};

    rwt_axis_skid #(
        .WIDTH(DWIDTH + TTWIDTH + 2)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_data  (skid_in),
        .in_valid (emit),
        .in_ready (s_ready),
        .out_data (skid_out),
        .out_valid(axi.m_axi_tvalid),
        .out_ready(axi.m_axi_tready)
    );

    assign {axi.m_axi_tdata, axi.m_axi_tlast, axi.m_axi_tag_valid, axi.m_axi_tag_type} = skid_out;

`ifdef RWT_TAG_EXTRACT_ERR_CNT_EN
    logic [15:0] err_count_q;

    always_ff @(posedge clk) begin
        if (reset || err_clear) begin
            err_count_q <= 16'd0;
        end else if (err && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_rwt_tag_extract.sv
// Directed and random stimulus against a lookahead reference parser with a scoreboard.
`timescale 1ns/1ps
module tb_rwt_tag_extract;

    localparam int unsigned DW = 64;
    localparam int unsigned TW = 7;
    localparam logic [63:0] E  = 64'hAAAA_AAAA_AAAA_AAAA;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        tags;
    } in_beat_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        tv;
        logic [6:0]  tt;
    } out_beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        use_tags = 1'b1;
    logic [63:0] tag_escape = E;
    logic        proto_err;
`ifdef RWT_TAG_EXTRACT_ERR_CNT_EN
    logic        err_clear = 1'b0;
    logic [15:0] err_count;
`endif

    rwt_tag_extract_if #(.DWIDTH(DW), .TTWIDTH(TW)) axi ();

    rwt_tag_extract #(
        .DWIDTH (DW),
        .TTWIDTH(TW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .use_tags  (use_tags),
        .tag_escape(tag_escape),
        .axi       (axi),
`ifdef RWT_TAG_EXTRACT_ERR_CNT_EN
        .err_clear (err_clear),
        .err_count (err_count),
`endif
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    in_beat_t  stim[$];
    out_beat_t exp_q[$];
    out_beat_t mdl_out[$];
    int        mdl_errs;
    int        n_checks = 0;
    int        n_pass = 0;
    int        err_seen = 0;
    longint    cycle = 0;
    int        ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       axi.m_axi_tready = 1'($urandom_range(0, 1));
            2:       axi.m_axi_tready = 1'b0;
            default: axi.m_axi_tready = 1'b1;
        endcase
    end

    function automatic logic [79:0] pk(input logic [63:0] d, input logic l, input logic tv,
                                       input logic [6:0] tt);
        return {7'd0, d, l, tv, tt};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic [63:0] d, input logic l, input logic t);
        in_beat_t b;
        b.data = d;
        b.last = l;
        b.tags = t;
        stim.push_back(b);
    endtask

    task automatic model_push(input logic [63:0] d, input logic l, input logic tv,
                              input logic [6:0] tt);
        out_beat_t o;
        o.data = d;
        o.last = l;
        o.tv   = tv;
        o.tt   = tv ? tt : 7'd0;
        mdl_out.push_back(o);
    endtask

    // Reference parser: reads escape pairs by lookahead rather than stepping a state machine.
    task automatic model_run();
        int         i;
        bit         pend;
        logic [6:0] pt;
        bit         tags;
        bit         start;
        in_beat_t   b;
        in_beat_t   f;
        i = 0;
        pend = 0;
        pt = '0;
        tags = 1;
        start = 1;
        mdl_out.delete();
        mdl_errs = 0;
        while (i < stim.size()) begin
            b = stim[i];
            if (start) tags = b.tags;
            if (!tags || b.data != E) begin
                model_push(b.data, b.last, tags && pend, pt);
                pend = 0;
                i += 1;
                start = b.last;
            end else if (b.last || i + 1 >= stim.size()) begin
                mdl_errs++;
                pend = 0;
                i += 1;
                start = 1;
            end else begin
                f = stim[i+1];
                i += 2;
                start = f.last;
                if (f.data == E) begin
                    model_push(E, f.last, pend, pt);
                    pend = 0;
                end else if (pend) begin
                    mdl_errs++;
                    pend = 0;
                end else if (f.last || f.data[63:7] != 57'd0) begin
                    mdl_errs++;
                end else begin
                    pend = 1;
                    pt = f.data[6:0];
                end
            end
        end
    endtask

    task automatic send(input in_beat_t b);
        int budget;
        bit rdy;
        budget = 0;
        axi.s_axi_tdata  = b.data;
        axi.s_axi_tlast  = b.last;
        use_tags         = b.tags;
        axi.s_axi_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            rdy = axi.s_axi_tready;
            @(posedge clk);
            if (rdy) break;
            budget++;
            if (budget > 1000) begin
                check("s_tready timeout", 80'd0, 80'd1);
                break;
            end
        end
        #1;
        axi.s_axi_tvalid = 1'b0;
    endtask

    task automatic scenario(input string name, output longint cyc);
        int     e0;
        int     t;
        longint c0;
        model_run();
        foreach (mdl_out[k]) exp_q.push_back(mdl_out[k]);
        e0 = err_seen;
        c0 = cycle;
        foreach (stim[k]) send(stim[k]);
        cyc = cycle - c0;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) check({name, " drain"}, 80'(exp_q.size()), 80'd0);
        repeat (4) @(posedge clk);
        #1;
        check({name, " proto_err count"}, 80'(err_seen - e0), 80'(mdl_errs));
        stim.delete();
    endtask

    task automatic pin(input string name, input int idx, input logic [63:0] d, input logic l,
                       input logic tv, input logic [6:0] tt);
        if (idx < mdl_out.size())
            check(name, pk(mdl_out[idx].data, mdl_out[idx].last, mdl_out[idx].tv,
                           mdl_out[idx].tt), pk(d, l, tv, tt));
        else
            check({name, " missing"}, 80'(mdl_out.size()), 80'(idx + 1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    function automatic logic [63:0] rand_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        if (w == E) w[0] = ~w[0];
        return w;
    endfunction

    // Scoreboard and hold-stability monitor.
    logic        hold_v = 1'b0;
    logic [79:0] held;
    always @(negedge clk) begin
        out_beat_t e;
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (proto_err) err_seen++;
            if (hold_v)
                check("hold stable", {axi.m_axi_tvalid, 6'd0,
                      pk(axi.m_axi_tdata, axi.m_axi_tlast, axi.m_axi_tag_valid,
                         axi.m_axi_tag_type)}[79:0], {1'b1, 6'd0, held}[79:0]);
            if (axi.m_axi_tvalid && axi.m_axi_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected beat", {16'd0, axi.m_axi_tdata}, 80'hdead);
                end else begin
                    e = exp_q.pop_front();
                    check("out beat", pk(axi.m_axi_tdata, axi.m_axi_tlast, axi.m_axi_tag_valid,
                          axi.m_axi_tag_type), pk(e.data, e.last, e.tv, e.tt));
                end
            end
            hold_v = axi.m_axi_tvalid && !axi.m_axi_tready;
            held   = pk(axi.m_axi_tdata, axi.m_axi_tlast, axi.m_axi_tag_valid,
                        axi.m_axi_tag_type);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint cyc;
        int     ty;
        int     kind;
        bit     lst;
        axi.s_axi_tvalid = 1'b0;
        axi.s_axi_tdata  = '0;
        axi.s_axi_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset tvalid", 80'(axi.m_axi_tvalid), 80'd0);
        check("reset tdata", 80'(axi.m_axi_tdata), 80'd0);
        check("reset tlast", 80'(axi.m_axi_tlast), 80'd0);
        check("reset tag_valid", 80'(axi.m_axi_tag_valid), 80'd0);
        check("reset tag_type", 80'(axi.m_axi_tag_type), 80'd0);
        check("reset proto_err", 80'(proto_err), 80'd0);
        check("reset s_tready", 80'(axi.s_axi_tready), 80'd1);
        reset = 1'b0;

        add(64'd1, 0, 1); add(64'd2, 0, 1); add(64'd3, 1, 1);
        scenario("plain", cyc);
        check("plain size", 80'(mdl_out.size()), 80'd3);
        pin("plain 0", 0, 64'd1, 0, 0, 0);
        pin("plain 2", 2, 64'd3, 1, 0, 0);

        add(64'd10, 0, 1); add(E, 0, 1); add(64'h05, 0, 1); add(64'd11, 0, 1); add(64'd12, 1, 1);
        scenario("tag", cyc);
        check("tag size", 80'(mdl_out.size()), 80'd3);
        pin("tag 0", 0, 64'd10, 0, 0, 0);
        pin("tag 1", 1, 64'd11, 0, 1, 7'd5);
        pin("tag 2", 2, 64'd12, 1, 0, 0);

        add(E, 0, 1); add(E, 0, 1); add(E, 0, 1); add(64'h03, 0, 1); add(E, 0, 1); add(E, 1, 1);
        scenario("literal", cyc);
        check("literal size", 80'(mdl_out.size()), 80'd2);
        pin("literal 0", 0, E, 0, 0, 0);
        pin("literal 1", 1, E, 1, 1, 7'd3);

        add(E, 1, 1);
        add(E, 0, 1); add(64'h80, 0, 1); add(64'd20, 1, 1);
        add(E, 0, 1); add(64'h05, 0, 1); add(E, 0, 1); add(64'h07, 0, 1); add(64'd21, 1, 1);
        scenario("errors", cyc);
        check("errors model count", 80'(mdl_errs), 80'd3);
        pin("errors 0", 0, 64'd20, 1, 0, 0);
        pin("errors 1", 1, 64'd21, 1, 0, 0);
`ifdef RWT_TAG_EXTRACT_ERR_CNT_EN
        check("err_count", 80'(err_count), 80'd3);
        err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
        check("err_count cleared", 80'(err_count), 80'd0);
`endif

        // Skid contents are dropped by reset.
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        add(64'd71, 0, 1); add(64'd72, 0, 1);
        foreach (stim[k]) send(stim[k]);
        stim.delete();
        check("skid full", 80'(axi.s_axi_tready), 80'd0);
        ready_mode = 0;
        do_reset();
        #1;
        check("skid flushed", 80'(axi.m_axi_tvalid), 80'd0);
        check("ready after reset", 80'(axi.s_axi_tready), 80'd1);

        // A pending descriptor is dropped by reset.
        add(E, 0, 1); add(64'h05, 0, 1);
        scenario("pending", cyc);
        do_reset();
        add(64'd11, 1, 1);
        scenario("post reset", cyc);
        pin("post reset 0", 0, 64'd11, 1, 0, 0);

        add(E, 0, 0); add(64'h05, 0, 0); add(64'd11, 1, 0);
        add(64'd30, 0, 1); add(E, 0, 0); add(64'h06, 0, 0); add(64'd31, 1, 0);
        add(E, 0, 0); add(E, 0, 1); add(64'd32, 1, 1);
        scenario("use_tags", cyc);
        check("use_tags size", 80'(mdl_out.size()), 80'd8);
        pin("use_tags 0", 0, E, 0, 0, 0);
        pin("use_tags 1", 1, 64'h05, 0, 0, 0);
        pin("use_tags 4", 4, 64'd31, 1, 1, 7'd6);
        pin("use_tags 6", 6, E, 0, 0, 0);

        for (int k = 0; k < 40; k++) add(rand_word(), k == 39, 1);
        scenario("throughput", cyc);
        check("throughput cycles", 80'(cyc), 80'd40);

        ready_mode = 1;
        while (stim.size() < 1000) begin
            kind = $urandom_range(0, 3);
            lst  = ($urandom_range(0, 7) == 0);
            ty   = $urandom_range(0, 127);
            case (kind)
                0: add(rand_word(), lst, 1);
                1: begin add(E, 0, 1); add(E, lst, 1); end
                2: begin add(E, 0, 1); add(64'(ty), 0, 1); add(rand_word(), lst, 1); end
                default: begin
                    add(E, 0, 1); add(64'(ty), 0, 1); add(E, 0, 1); add(E, lst, 1);
                end
            endcase
        end
        add(rand_word(), 1, 1);
        scenario("random", cyc);
        ready_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
